// File: rtl/conv_bus_master.sv
// Upstream sequencer for conv_top: turns weight/image/result valid-ready streams
// into the i_ctrl + shared iobus word protocol, one window in flight at a time.
module conv_bus_master #(
  parameter int BUS_WIDTH = 32,
  parameter int N_INPUT   = 49
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] s_w_data,
  input  logic                 s_w_valid,
  output logic                 s_w_ready,
  input  logic [BUS_WIDTH-1:0] s_i_data,
  input  logic                 s_i_valid,
  output logic                 s_i_ready,
  output logic [BUS_WIDTH-1:0] m_res_data,
  output logic                 m_res_valid,
  input  logic                 m_res_ready,
  input  logic                 i_reload_w,
  output logic [1:0]           o_ctrl,
  input  logic                 i_val,
  input  logic                 i_wreq,
  input  logic                 i_ireq,
  inout  wire  [BUS_WIDTH-1:0] iobus,
  output logic [15:0]          o_win_cnt
);

  localparam int CNT_W = $clog2(N_INPUT + 1);

  localparam logic [2:0] LOAD_W   = 3'd0;
  localparam logic [2:0] LOAD_I   = 3'd1;
  localparam logic [2:0] WAIT_VAL = 3'd2;
  localparam logic [2:0] READ     = 3'd3;
  localparam logic [2:0] RES_OUT  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_INPUT - 1);

  localparam logic [1:0] CTRL_IDLE  = 2'd0;
  localparam logic [1:0] CTRL_WGT   = 2'd1;
  localparam logic [1:0] CTRL_IMG   = 2'd2;
  localparam logic [1:0] CTRL_READ  = 2'd3;

  logic [2:0]           state;
  logic [CNT_W-1:0]     word_cnt;
  logic [BUS_WIDTH-1:0] bus_q;
  logic                 reload_pend;
  logic                 w_acc;
  logic                 i_acc;
  logic                 win_start_reload;

  // A pending reload only blocks images at a window boundary, so a window
  // already under way is always completed.
  always_comb begin
    win_start_reload = reload_pend && (word_cnt == '0);
    s_w_ready        = (state == LOAD_W) && i_wreq;
    s_i_ready        = (state == LOAD_I) && i_ireq && !win_start_reload;
    w_acc            = s_w_valid && s_w_ready;
    i_acc            = s_i_valid && s_i_ready;
  end

  assign iobus = (o_ctrl != CTRL_READ) ? bus_q : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_W;
      word_cnt    <= '0;
      bus_q       <= '0;
      reload_pend <= 1'b0;
      o_ctrl      <= CTRL_IDLE;
      m_res_data  <= '0;
      m_res_valid <= 1'b0;
      o_win_cnt   <= '0;
    end else begin
      o_ctrl <= CTRL_IDLE;
      if (i_reload_w) reload_pend <= 1'b1;

      case (state)
        LOAD_W: begin
          if (w_acc) begin
            o_ctrl <= CTRL_WGT;
            bus_q  <= s_w_data;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= LOAD_I;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        LOAD_I: begin
          if (win_start_reload) begin
            reload_pend <= 1'b0;
            state       <= LOAD_W;
          end else if (i_acc) begin
            o_ctrl <= CTRL_IMG;
            bus_q  <= s_i_data;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= WAIT_VAL;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        WAIT_VAL: begin
          if (i_val) begin
            o_ctrl <= CTRL_READ;
            state  <= READ;
          end
        end

        // conv_top drives iobus throughout this single ctrl=3 cycle.
        READ: begin
          m_res_data  <= iobus;
          m_res_valid <= 1'b1;
          o_win_cnt   <= o_win_cnt + 16'd1;
          state       <= RES_OUT;
        end

        RES_OUT: begin
          if (m_res_ready) begin
            m_res_valid <= 1'b0;
            if (reload_pend) begin
              reload_pend <= 1'b0;
              state       <= LOAD_W;
            end else begin
              state <= LOAD_I;
            end
          end
        end

        default: state <= LOAD_W;
      endcase
    end
  end

endmodule
